// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit with a forwarding FIFO store buffer draining into a RAM write port
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
module mem_access_unit #(
    parameter int ADDR_W   = `ADDRESS_SIZE,
    parameter int DATA_W   = `DATA_SIZE,
    parameter int SB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              sb_empty,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [DATA_W-1:0] mem_read_data
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    typedef enum logic [1:0] {IDLE, LD_RD, LD_RSP} state_t;
    state_t            state_q, state_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
    logic [ADDR_W-1:0] sb_addr_d [SB_DEPTH];
    logic [DATA_W-1:0] sb_data_q [SB_DEPTH];
    logic [DATA_W-1:0] sb_data_d [SB_DEPTH];
    logic [ADDR_W-1:0] last_addr_q, last_addr_d, rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] last_data_q, last_data_d, rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              sb_full, accept, push, ld_acc, fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign sb_full           = count_q == CNT_W'(SB_DEPTH);
    assign sb_empty          = count_q == '0;
    assign accept            = req_valid && req_ready;
    assign push              = accept && req_is_store;
    assign ld_acc            = accept && !req_is_store;
    assign mem_write_address = mem_write_enable ? sb_addr_q[head_q] : last_addr_q;
    assign mem_write_data    = mem_write_enable ? sb_data_q[head_q] : last_data_q;
    assign mem_read_address  = rd_addr_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_data          = rsp_data_q;

    // Scan oldest to youngest so the youngest match wins; the popping head is still a candidate.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (CNT_W'(i) < count_q && sb_addr_q[head_q + PTR_W'(i)] == req_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data_q[head_q + PTR_W'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            last_addr_q <= '0;
            last_data_q <= '0;
            rd_addr_q   <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
            rd_addr_q   <= rd_addr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        sb_addr_q <= sb_addr_d;
        sb_data_q <= sb_data_d;
    end

    always_comb begin
        state_d = state_q == LD_RD  ? LD_RSP :
                  state_q == LD_RSP ? IDLE   :
                  (ld_acc && !fwd_hit) ? LD_RD : IDLE;
    end

    // Draining pauses in LD_RD so the RAM port serves the read; reset also blocks it.
    always_comb begin
        req_ready        = !reset && state_q == IDLE && (req_is_store ? !sb_full : 1'b1);
        mem_write_enable = !reset && !sb_empty && state_q != LD_RD;
    end

    always_comb begin
        head_d    = head_q + PTR_W'(mem_write_enable);
        tail_d    = tail_q + PTR_W'(push);
        count_d   = count_q + CNT_W'(push) - CNT_W'(mem_write_enable);
        sb_addr_d = sb_addr_q;
        sb_data_d = sb_data_q;
        if (push) begin
            sb_addr_d[tail_q] = req_addr;
            sb_data_d[tail_q] = req_wdata;
        end
        last_addr_d = mem_write_address;
        last_data_d = mem_write_data;
        rd_addr_d   = (ld_acc && !fwd_hit) ? req_addr : rd_addr_q;
        rsp_valid_d = state_q == LD_RD || (ld_acc && fwd_hit);
        rsp_data_d  = state_q == LD_RD ? mem_read_data : (ld_acc && fwd_hit) ? fwd_data : rsp_data_q;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit against a queue-based model
module tb_mem_access_unit;
    localparam int AW = 8, DW = 16, DEPTH = 4;
    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;

    logic          clk = 1'b0;
    logic          reset, req_valid, req_ready, req_is_store, rsp_valid, sb_empty, mem_write_enable;
    logic [AW-1:0] req_addr, mem_write_address, mem_read_address;
    logic [DW-1:0] req_wdata, rsp_data, mem_write_data, mem_read_data;
    logic [DW-1:0] phys_ram [256];
    logic          init_ram = 1'b0;
    int            ram_salt;

    ent_t          sbq[$];
    int            phase;
    logic          m_rsp_valid;
    logic [DW-1:0] m_rsp_data, m_last_d;
    logic [AW-1:0] m_last_a, m_rd_addr;
    logic [DW-1:0] model_ram [256];
    logic          exp_ready, exp_we, exp_empty;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;
    int            vectors = 0, miscompares = 0;

    mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .SB_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .sb_empty(sb_empty),
        .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_read_address(mem_read_address),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int i);
        return DW'(i * 40503 + ram_salt);
    endfunction

    assign mem_read_data = phys_ram[mem_read_address];
    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 256; i++) phys_ram[i] <= pat(i);
        end else if (mem_write_enable === 1'b1) begin
            phys_ram[mem_write_address] <= mem_write_data;
        end
    end

    task automatic drive(input logic r, input logic v, input logic s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        reset = r; req_valid = v; req_is_store = s; req_addr = a; req_wdata = d;
        exp_ready = !r && phase == 0 && (s ? sbq.size() < DEPTH : 1'b1);
        exp_we    = !r && sbq.size() > 0 && phase != 1;
        exp_waddr = exp_we ? sbq[0].a : m_last_a;
        exp_wdata = exp_we ? sbq[0].d : m_last_d;
        exp_empty = sbq.size() == 0;
        #1;
    endtask

    task automatic tick;
        logic          acc, hit;
        logic [DW-1:0] fd;
        @(posedge clk);
        acc = req_valid && exp_ready;
        if (reset) begin
            sbq.delete(); phase = 0; m_rsp_valid = 0; m_rsp_data = '0;
            m_last_a = '0; m_last_d = '0; m_rd_addr = '0;
        end else begin
            hit = 0; fd = '0;
            if (acc && !req_is_store) foreach (sbq[i]) if (sbq[i].a == req_addr) begin hit = 1; fd = sbq[i].d; end
            m_rsp_valid = 0;
            if (phase == 1) begin m_rsp_data = model_ram[m_rd_addr]; m_rsp_valid = 1; phase = 2; end
            else if (phase == 2) phase = 0;
            else if (acc && !req_is_store) begin
                if (hit) begin m_rsp_valid = 1; m_rsp_data = fd; end
                else begin m_rd_addr = req_addr; phase = 1; end
            end
            if (exp_we) begin
                model_ram[sbq[0].a] = sbq[0].d; m_last_a = sbq[0].a; m_last_d = sbq[0].d;
                void'(sbq.pop_front());
            end
            if (acc && req_is_store) sbq.push_back(ent_t'{a: req_addr, d: req_wdata});
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        init_ram = 1'b1;
        drive(1, 1, 1, 8'h10, 16'h0001);
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        tick;
        init_ram = 1'b0;
        drive(1, 0, 0, 8'h00, 16'h0000);
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (rsp_data !== 16'h0) begin miscompares++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        vectors++; if (sb_empty !== 1'b1) begin miscompares++; $display("FAIL rst_sb_empty: got %b want 1", sb_empty); end
        vectors++; if (mem_read_address !== 8'h0) begin miscompares++; $display("FAIL rst_raddr: got %h want 0", mem_read_address); end
        vectors++; if ({mem_write_address, mem_write_data} !== 24'h0) begin miscompares++; $display("FAIL rst_wport: got %h/%h want 0/0", mem_write_address, mem_write_data); end
        tick;
        drive(0, 0, 0, 8'h00, 16'h0000);
        vectors++; if (mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b want 0", mem_write_enable); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_idle_ready: got %b want 1", req_ready); end
        tick;
    endtask

    task automatic test_store_drain;
        drive(0, 1, 1, 8'h10, 16'h00AA);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL st_ready: got %b want 1", req_ready); end
        tick;
        drive(0, 0, 0, 8'h00, 16'h0000);
        vectors++; if (mem_write_enable !== 1'b1) begin miscompares++; $display("FAIL st_we: got %b want 1", mem_write_enable); end
        vectors++; if (mem_write_address !== 8'h10 || mem_write_data !== 16'h00AA) begin miscompares++; $display("FAIL st_wport: got %h/%h want 10/00aa", mem_write_address, mem_write_data); end
        tick;
        drive(0, 0, 0, 8'h00, 16'h0000);
        vectors++; if (sb_empty !== 1'b1 || mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL st_drained: got empty=%b we=%b want 1/0", sb_empty, mem_write_enable); end
        vectors++; if (mem_write_address !== 8'h10 || mem_write_data !== 16'h00AA) begin miscompares++; $display("FAIL st_hold: got %h/%h want 10/00aa", mem_write_address, mem_write_data); end
        tick;
    endtask

    task automatic test_load_miss;
        drive(0, 1, 0, 8'h10, 16'h0000);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL ld_ready: got %b want 1", req_ready); end
        tick;
        drive(0, 1, 0, 8'h10, 16'h0000);
        vectors++; if (mem_write_enable !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ld_rd: got we=%b rdy=%b rv=%b want 0/0/0", mem_write_enable, req_ready, rsp_valid); end
        vectors++; if (mem_read_address !== 8'h10) begin miscompares++; $display("FAIL ld_raddr: got %h want 10", mem_read_address); end
        tick;
        drive(0, 1, 0, 8'h10, 16'h0000);
        vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h00AA || req_ready !== 1'b0) begin miscompares++; $display("FAIL ld_rsp: got rv=%b data=%h rdy=%b want 1/00aa/0", rsp_valid, rsp_data, req_ready); end
        tick;
        drive(0, 0, 0, 8'h00, 16'h0000);
        vectors++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h00AA) begin miscompares++; $display("FAIL ld_after: got rv=%b data=%h want 0/00aa", rsp_valid, rsp_data); end
        tick;
    endtask

    task automatic test_forward;
        drive(0, 1, 1, 8'h20, 16'h0001); tick;
        drive(0, 1, 1, 8'h20, 16'h0002);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL fw_st_ready: got %b want 1", req_ready); end
        tick;
        drive(0, 1, 0, 8'h20, 16'h0000); tick;
        drive(0, 0, 0, 8'h00, 16'h0000);
        vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0002) begin miscompares++; $display("FAIL fw_data: got rv=%b data=%h want 1/0002", rsp_valid, rsp_data); end
        vectors++; if (mem_read_address !== 8'h10 || req_ready !== 1'b1) begin miscompares++; $display("FAIL fw_no_rd: got raddr=%h rdy=%b want 10/1", mem_read_address, req_ready); end
        tick;
        drive(0, 0, 0, 8'h00, 16'h0000);
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL fw_pulse: got %b want 0", rsp_valid); end
        tick;
    endtask

    task automatic test_head_pop_forward;
        drive(0, 1, 1, 8'h30, 16'h5A5A); tick;
        drive(0, 1, 0, 8'h30, 16'h0000);
        vectors++; if (mem_write_enable !== 1'b1 || mem_write_address !== 8'h30 || mem_write_data !== 16'h5A5A) begin miscompares++; $display("FAIL hp_write: got we=%b %h/%h want 1 30/5a5a", mem_write_enable, mem_write_address, mem_write_data); end
        tick;
        drive(0, 0, 0, 8'h00, 16'h0000);
        vectors++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h5A5A) begin miscompares++; $display("FAIL hp_fwd: got rv=%b data=%h want 1/5a5a", rsp_valid, rsp_data); end
        vectors++; if (phys_ram[8'h30] !== 16'h5A5A || sb_empty !== 1'b1) begin miscompares++; $display("FAIL hp_ram: got ram=%h empty=%b want 5a5a/1", phys_ram[8'h30], sb_empty); end
        tick;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 1, AW'($urandom_range(7)), DW'($urandom));
            vectors++; if (req_ready !== exp_ready) begin miscompares++; $display("FAIL b2b_st_ready[%0d]: got %b want %b", i, req_ready, exp_ready); end
            tick;
        end
        drive(0, 1, 0, 8'h55, 16'h0000);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ld_ready: got %b want 1", req_ready); end
        tick;
        for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 8'h00, 16'h0000); tick; end
    endtask

    task automatic test_reset_mid_load;
        drive(0, 1, 1, 8'h40, 16'h1111); tick;
        drive(0, 1, 0, 8'h41, 16'h0000); tick;
        drive(1, 0, 0, 8'h00, 16'h0000);
        vectors++; if (mem_write_enable !== 1'b0 || req_ready !== 1'b0) begin miscompares++; $display("FAIL rm_in_rst: got we=%b rdy=%b want 0/0", mem_write_enable, req_ready); end
        tick;
        drive(0, 0, 0, 8'h00, 16'h0000);
        vectors++; if (rsp_valid !== 1'b0 || sb_empty !== 1'b1 || mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL rm_after: got rv=%b empty=%b we=%b want 0/1/0", rsp_valid, sb_empty, mem_write_enable); end
        tick;
        drive(0, 0, 0, 8'h00, 16'h0000);
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rm_dropped: got %b want 0", rsp_valid); end
        tick;
    endtask

    task automatic test_random(input int n);
        for (int c = 0; c < n; c++) begin
            drive($urandom_range(63) == 0, $urandom_range(9) < 7, 1'($urandom_range(1)), AW'($urandom_range(7)), DW'($urandom));
            vectors++; if (req_ready !== exp_ready) begin miscompares++; $display("FAIL rnd_ready@%0d: got %b want %b", c, req_ready, exp_ready); end
            vectors++; if (mem_write_enable !== exp_we) begin miscompares++; $display("FAIL rnd_we@%0d: got %b want %b", c, mem_write_enable, exp_we); end
            vectors++; if (mem_write_address !== exp_waddr || mem_write_data !== exp_wdata) begin miscompares++; $display("FAIL rnd_wport@%0d: got %h/%h want %h/%h", c, mem_write_address, mem_write_data, exp_waddr, exp_wdata); end
            vectors++; if (rsp_valid !== m_rsp_valid || rsp_data !== m_rsp_data) begin miscompares++; $display("FAIL rnd_rsp@%0d: got %b/%h want %b/%h", c, rsp_valid, rsp_data, m_rsp_valid, m_rsp_data); end
            vectors++; if (sb_empty !== exp_empty) begin miscompares++; $display("FAIL rnd_empty@%0d: got %b want %b", c, sb_empty, exp_empty); end
            if (phase == 1) begin
                vectors++; if (mem_read_address !== m_rd_addr) begin miscompares++; $display("FAIL rnd_raddr@%0d: got %h want %h", c, mem_read_address, m_rd_addr); end
            end
            tick;
        end
    endtask

    initial begin
        ram_salt = int'($urandom);
        for (int i = 0; i < 256; i++) model_ram[i] = pat(i);
        phase = 0; m_rsp_valid = 0; m_rsp_data = '0; m_last_a = '0; m_last_d = '0; m_rd_addr = '0;
        test_reset;
        test_store_drain;
        test_load_miss;
        test_forward;
        test_head_pop_forward;
        test_back_to_back;
        test_reset_mid_load;
        test_random(800);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
